ifetch_unit: RTL and testbench
==============================

// Module: ifetch_unit
// PURPOSE
//  Fetch stage of the RV32I multicycle core; sits directly upstream of the combinational
//  instruction memory. Owns the PC, drives the word-aligned fetch address, latches the
//  returned word into the instruction register (IR) and hands it to decode with valid/ready.
//  Also accepts branch/jump/trap redirects from the control unit.
// PARAMETERS
//  XLEN         32            datapath / PC width
//  INSTR_WIDTH  32            instruction width
//  RESET_PC     32'h0000_0000 PC loaded on reset
//  NOP_INSTR    32'h0000_0013 IR value when empty/flushed (addi x0,x0,0)
// PORTS
//  clk             in   1            core clock, all state updates on rising edge
//  rst             in   1            synchronous, active-high reset
//  imem_pc         out  XLEN         fetch byte address to imem (imem drops pc[1:0])
//  imem_instr      in   INSTR_WIDTH  instruction word from imem, valid same cycle as imem_pc
//  redirect_valid  in   1            control requests PC change this cycle
//  redirect_pc     in   XLEN         redirect target byte address
//  ir              out  INSTR_WIDTH  latched instruction for decode
//  ir_pc           out  XLEN         address ir was fetched from
//  ir_pc_plus4     out  XLEN         ir_pc + 4 (mod 2^XLEN), for JAL/JALR link
//  ir_valid        out  1            ir holds an unconsumed instruction
//  ir_ready        in   1            decode accepts ir this cycle
//  misalign_trap   out  1            misaligned redirect trapped (macro only; else tied 0)
// BEHAVIOUR
//  - FSM states: S_FETCH, S_VALID, S_TRAP (S_TRAP exists only with macro).
//  - Reset (rst=1 at edge): pc=RESET_PC, state=S_FETCH, ir=NOP_INSTR, ir_pc=RESET_PC,
//    ir_valid=0, misalign_trap=0. rst mid-operation discards IR and any pending redirect.
//  - imem_pc = pc register (combinational from state, never from inputs).
//  - S_FETCH: at edge ir<=imem_instr, ir_pc<=pc, pc<=pc+4, ir_valid<=1, ->S_VALID.
//  - S_VALID: hold ir/ir_pc/ir_valid stable while ir_ready=0. Handshake = ir_valid&ir_ready;
//    on handshake ir_valid<=0, ->S_FETCH. Throughput: 1 instruction per 2 cycles max.
//  - Redirect (any state, highest priority below rst): pc<=redirect_pc, ir<=NOP_INSTR,
//    ir_valid<=0, ->S_FETCH. Latency: redirect at edge N -> imem_pc=target after N ->
//    ir_valid=1 after edge N+1.
//  - Redirect coincident with handshake: handshake counts as consumed; redirect wins PC.
//  - Redirect while in S_FETCH: in-flight fetch is dropped, never presented to decode.
//  - PC arithmetic modulo 2^XLEN: pc=32'hFFFF_FFFC advances to 32'h0000_0000, no flag.
//  - ir_pc_plus4 registered alongside ir_pc; never combinationally from pc.
//  - ir_ready while ir_valid=0 is ignored.
// CONFIGURATION
//  IFETCH_MISALIGN_TRAP_EN defined:
//   - redirect with redirect_pc[1:0]!=0: pc<=redirect_pc (unmodified), ir_valid<=0,
//     misalign_trap<=1, ->S_TRAP. S_TRAP: no fetch, ir_valid=0, misalign_trap held 1;
//     ir_pc<=offending target (for mtval). Exit only via aligned redirect (->S_FETCH,
//     misalign_trap<=0) or rst. Misaligned redirect in S_TRAP stays in S_TRAP, updates ir_pc.
//  IFETCH_MISALIGN_TRAP_EN undefined:
//   - redirect_pc[1:0] forced to 2'b00 on load; S_TRAP absent; misalign_trap tied 0.
// TESTING
//  1 rst 2 cycles, imem[0]=32'h0010_0093, ir_ready=1 -> ir=32'h0010_0093, ir_pc=0,
//    ir_valid=1 one edge after rst release; next fetch imem_pc=4.
//  2 ir_ready=0 for 5 cycles in S_VALID -> ir/ir_pc/ir_valid stable, imem_pc unchanged.
//  3 redirect_pc=32'h0000_0040 during S_VALID with ir_ready=1 -> next ir_pc=32'h40,
//    instruction at 0x40 in ir, no fetch from old pc+4 delivered.
//  4 redirect_pc=32'hFFFF_FFFC, two fetches -> ir_pc 32'hFFFF_FFFC then 32'h0000_0000,
//    ir_pc_plus4 of first = 32'h0000_0000.
//  5 (macro on) redirect_pc=32'h0000_0042 -> misalign_trap=1, ir_valid=0, ir_pc=32'h42;
//    then redirect_pc=32'h100 -> misalign_trap=0, ir_pc=32'h100 fetched.
//    (macro off) same stimulus -> ir_pc=32'h40, misalign_trap=0.
//  6 rst asserted in S_VALID with redirect_valid=1 -> pc=RESET_PC, ir=NOP_INSTR, ir_valid=0.

Source files
------------

// File: rtl/ifetch_unit.sv
// Fetch stage of the RV32I multicycle core: owns the PC, latches imem output into IR, hands off to decode.
// Optional misaligned-redirect trapping is enabled by defining IFETCH_MISALIGN_TRAP_EN.
module ifetch_unit #(
  parameter int unsigned             XLEN        = 32,
  parameter int unsigned             INSTR_WIDTH = 32,
  parameter logic [XLEN-1:0]         RESET_PC    = 32'h0000_0000,
  parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [XLEN-1:0]        imem_pc,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic [XLEN-1:0]        ir_pc,
  output logic [XLEN-1:0]        ir_pc_plus4,
  output logic                   ir_valid,
  input  logic                   ir_ready,
  output logic                   misalign_trap
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_VALID
`ifdef IFETCH_MISALIGN_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t          state, next_state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next_seq;
  logic [XLEN-1:0] target;
  logic            misaligned;

  assign imem_pc     = pc;
  assign pc_next_seq = pc + XLEN'(4);

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign target     = redirect_pc;
  assign misaligned = (redirect_pc[1:0] != 2'b00);
`else
  // low address bits are dropped on load; masking keeps every input bit referenced
  assign target        = redirect_pc & ~XLEN'(3);
  assign misaligned    = 1'b0;
  assign misalign_trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (redirect_valid) begin
      next_state = S_FETCH;
`ifdef IFETCH_MISALIGN_TRAP_EN
      if (misaligned) next_state = S_TRAP;
`endif
    end else begin
      case (state)
        S_FETCH: next_state = S_VALID;
        S_VALID: if (ir_valid && ir_ready) next_state = S_FETCH;
        default: next_state = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      ir          <= NOP_INSTR;
      ir_pc       <= RESET_PC;
      ir_pc_plus4 <= RESET_PC + XLEN'(4);
      ir_valid    <= 1'b0;
    end else if (redirect_valid) begin
      // a coincident handshake is simply absorbed: the IR is flushed either way
      pc       <= target;
      ir       <= NOP_INSTR;
      ir_valid <= 1'b0;
      if (misaligned) begin
        ir_pc       <= redirect_pc;
        ir_pc_plus4 <= redirect_pc + XLEN'(4);
      end
    end else begin
      case (state)
        S_FETCH: begin
          ir          <= imem_instr;
          ir_pc       <= pc;
          ir_pc_plus4 <= pc_next_seq;
          pc          <= pc_next_seq;
          ir_valid    <= 1'b1;
        end
        S_VALID: if (ir_ready) ir_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef IFETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst)                 misalign_trap <= 1'b0;
    else if (redirect_valid) misalign_trap <= misaligned;
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: expected handoffs queued at stimulus time, compared at each handshake.
module tb_ifetch_unit;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic [31:0] ir_pc_plus4;
  logic        ir_valid;
  logic        ir_ready;
  logic        misalign_trap;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  localparam logic [31:0] NOP = 32'h0000_0013;

  ifetch_unit #(
    .XLEN(32),
    .INSTR_WIDTH(32),
    .RESET_PC(32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_pc(imem_pc),
    .imem_instr(imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .ir(ir),
    .ir_pc(ir_pc),
    .ir_pc_plus4(ir_pc_plus4),
    .ir_valid(ir_valid),
    .ir_ready(ir_ready),
    .misalign_trap(misalign_trap)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr[31:2] == 30'd0) return 32'h0010_0093;
    return {addr[31:2], 2'b11} ^ 32'h5A5A_0000;
  endfunction

  always_comb imem_instr = mem_word(imem_pc);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.instr = mem_word(a);
    e.pc    = a;
    e.pc4   = a + 32'd4;
    sb.push_back(e);
  endtask

  // Scoreboard side: every handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && ir_valid === 1'b1 && ir_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("hs_unexpected_pc", ir_pc, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hs_ir", ir, e.instr);
        chk("hs_ir_pc", ir_pc, e.pc);
        chk("hs_ir_pc_plus4", ir_pc_plus4, e.pc4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; ir_ready = 1'b0;
    tick();
    chk("rst_imem_pc", imem_pc, 32'h0);
    chk("rst_ir", ir, NOP);
    chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_ir_pc", ir_pc, 32'h0);
    chk("rst_trap", {31'd0, misalign_trap}, 32'd0);
    tick();

    // 1: first fetch after reset release
    rst = 1'b0; ir_ready = 1'b1;
    push(32'h0);
    tick();
    chk("t1_ir_valid", {31'd0, ir_valid}, 32'd1);
    chk("t1_ir", ir, 32'h0010_0093);
    chk("t1_ir_pc", ir_pc, 32'h0);
    chk("t1_imem_pc", imem_pc, 32'h4);
    tick();
    chk("t1_consumed_valid", {31'd0, ir_valid}, 32'd0);

    // 2: stall in S_VALID
    ir_ready = 1'b0;
    push(32'h4);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_ir", ir, mem_word(32'h4));
      chk("t2_ir_pc", ir_pc, 32'h4);
      chk("t2_ir_valid", {31'd0, ir_valid}, 32'd1);
      chk("t2_imem_pc", imem_pc, 32'h8);
      tick();
    end

    // 3: redirect coincident with handshake
    ir_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("t3_imem_pc", imem_pc, 32'h40);
    chk("t3_flushed_valid", {31'd0, ir_valid}, 32'd0);
    chk("t3_flushed_ir", ir, NOP);
    push(32'h40);
    tick();
    chk("t3_ir_pc", ir_pc, 32'h40);
    chk("t3_ir", ir, mem_word(32'h40));
    tick();

    // redirect while in S_FETCH drops the fetch of 0x44; 4: PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("t4_imem_pc", imem_pc, 32'hFFFF_FFFC);
    chk("t4_dropped_valid", {31'd0, ir_valid}, 32'd0);
    push(32'hFFFF_FFFC);
    push(32'h0);
    tick();
    chk("t4_ir_pc_a", ir_pc, 32'hFFFF_FFFC);
    chk("t4_plus4_a", ir_pc_plus4, 32'h0);
    tick();
    chk("t4_wrap_imem_pc", imem_pc, 32'h0);
    tick();
    chk("t4_ir_pc_b", ir_pc, 32'h0);
    tick();

    // 5: misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      chk("t5_trap", {31'd0, misalign_trap}, 32'd1);
      chk("t5_ir_valid", {31'd0, ir_valid}, 32'd0);
      chk("t5_ir_pc", ir_pc, 32'h42);
      tick();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("t5_trap_clr", {31'd0, misalign_trap}, 32'd0);
    chk("t5_imem_pc", imem_pc, 32'h100);
    push(32'h100);
    tick();
    chk("t5_fetch_ir_pc", ir_pc, 32'h100);
    tick();
`else
    chk("t5_trap_tied", {31'd0, misalign_trap}, 32'd0);
    chk("t5_imem_pc", imem_pc, 32'h40);
    push(32'h40);
    tick();
    chk("t5_ir_pc", ir_pc, 32'h40);
    chk("t5_trap_tied2", {31'd0, misalign_trap}, 32'd0);
    tick();
`endif

    // 6: reset in S_VALID beats a redirect
    ir_ready = 1'b0;
    tick();
    chk("t6_pre_valid", {31'd0, ir_valid}, 32'd1);
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    chk("t6_imem_pc", imem_pc, 32'h0);
    chk("t6_ir", ir, NOP);
    chk("t6_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("t6_ir_pc", ir_pc, 32'h0);
    rst = 1'b0; redirect_valid = 1'b0; ir_ready = 1'b1;
    push(32'h0);
    tick();
    chk("t6_refetch_ir_pc", ir_pc, 32'h0);
    tick();
    ir_ready = 1'b0;
    tick();
    tick();
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
